// File: rtl/disp_pkg.sv
// Shared codes, slot numbering and FSM states for the 7-seg scan controller.
// Also holds the add-3 nibble adjust used by the serial binary-to-BCD converter.
package disp_pkg;

    localparam logic [3:0] CODE_MINUS = 4'd10;
    localparam logic [3:0] CODE_BLANK = 4'd11;

    localparam logic [1:0] SLOT_UNITS = 2'd0;
    localparam logic [1:0] SLOT_SIGN  = 2'd1;
    localparam logic [1:0] SLOT_HUND  = 2'd2;
    localparam logic [1:0] SLOT_TENS  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } state_t;

    function automatic logic [11:0] bcd_adj(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int i = 0; i < 3; i++) begin
            if (b[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_scan_tick.sv
// Display slot prescaler: one tick every SCAN_DIV clocks, advancing a 2-bit slot.
// The tick is combinational on the wrap so the parent can load outputs in the same edge.
module scan_tick #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       tick,
    output logic [1:0] slot
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_slot;

    assign tick = (r_cnt == LAST);
    assign slot = r_slot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_slot <= 2'd0;
        end else if (tick) begin
            r_cnt  <= '0;
            r_slot <= r_slot + 2'd1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Captures a signed magnitude, converts it to BCD one bit per clock, commits the
// digits atomically to shadow registers and time-multiplexes the 4 anodes.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int W        = 8,
    parameter int SCAN_DIV = 50000,
    parameter int LZ_BLANK = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] mag,
    input  logic         neg,
    output logic         busy,
    output logic         done,
    output logic [3:0]   an,
    output logic [3:0]   code
);

    localparam logic [3:0] LAST_STEP = 4'(W - 1);

    state_t         r_state;
    logic [W-1:0]   r_sh;
    logic [11:0]    r_bcd;
    logic [3:0]     r_cnt;
    logic           r_sgn;
    logic [W-1:0]   r_pmag;
    logic           r_psgn;
    logic           r_pend;
    logic [3:0]     r_dh, r_dt, r_du;
    logic           r_ds;
    logic           r_busy, r_done;
    logic [3:0]     r_an, r_code;

    logic           w_tick;
    logic [1:0]     w_slot, w_nslot;
    logic [11:0]    w_adj;
    logic [W+11:0]  w_cat;
    logic           w_lsgn;
    logic           w_hblank, w_tblank;
    logic [3:0]     w_code;

    scan_tick #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick),
        .slot  (w_slot)
    );

    assign w_adj  = bcd_adj(r_bcd);
    assign w_cat  = {w_adj, r_sh} << 1;
    // -0 must show a blank sign slot, so the sign is qualified at capture
    assign w_lsgn = neg & (|mag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sh    <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_sgn   <= 1'b0;
            r_pmag  <= '0;
            r_psgn  <= 1'b0;
            r_pend  <= 1'b0;
            r_dh    <= '0;
            r_dt    <= '0;
            r_du    <= '0;
            r_ds    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (load) begin
                        r_sh    <= mag;
                        r_sgn   <= w_lsgn;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= CONV;
                    end
                end
                CONV: begin
                    r_bcd <= w_cat[W+11:W];
                    r_sh  <= w_cat[W-1:0];
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == LAST_STEP)
                        r_state <= COMMIT;
                    if (load) begin
                        r_pmag <= mag;
                        r_psgn <= w_lsgn;
                        r_pend <= 1'b1;
                    end
                end
                COMMIT: begin
                    r_du   <= r_bcd[3:0];
                    r_dt   <= r_bcd[7:4];
                    r_dh   <= r_bcd[11:8];
                    r_ds   <= r_sgn;
                    r_done <= 1'b1;
                    r_bcd  <= '0;
                    r_cnt  <= '0;
                    r_pend <= 1'b0;
                    // a load landing on this edge is newer than any pending value
                    if (load) begin
                        r_sh    <= mag;
                        r_sgn   <= w_lsgn;
                        r_state <= CONV;
                    end else if (r_pend) begin
                        r_sh    <= r_pmag;
                        r_sgn   <= r_psgn;
                        r_state <= CONV;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_nslot  = w_slot + 2'd1;
    assign w_hblank = (LZ_BLANK != 0) && (r_dh == 4'd0);
    assign w_tblank = w_hblank && (r_dt == 4'd0);

    always_comb begin
        w_code = CODE_BLANK;
        unique case (w_nslot)
            SLOT_UNITS: w_code = r_du;
            SLOT_SIGN:  w_code = r_ds ? CODE_MINUS : CODE_BLANK;
            SLOT_HUND:  w_code = w_hblank ? CODE_BLANK : r_dh;
            SLOT_TENS:  w_code = w_tblank ? CODE_BLANK : r_dt;
            default:    w_code = CODE_BLANK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an   <= 4'b1111;
            r_code <= CODE_BLANK;
        end else if (w_tick) begin
            r_an   <= ~(4'b0001 << w_nslot);
            r_code <= w_code;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign an   = r_an;
    assign code = r_code;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Randomized self-checking bench for disp_scan_ctrl against a decimal display model.
// Two instances share stimulus: one with leading-zero blanking, one without.
module tb_disp_scan_ctrl;

    localparam int W  = 8;
    localparam int SD = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         load  = 1'b0;
    logic         neg   = 1'b0;
    logic [W-1:0] mag   = '0;
    logic         busy0, done0, busy1, done1;
    logic [3:0]   an0, code0, an1, code1;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    always #5 clk = ~clk;

    disp_scan_ctrl #(.W(W), .SCAN_DIV(SD), .LZ_BLANK(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .load(load), .mag(mag), .neg(neg),
        .busy(busy0), .done(done0), .an(an0), .code(code0)
    );

    disp_scan_ctrl #(.W(W), .SCAN_DIV(SD), .LZ_BLANK(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .load(load), .mag(mag), .neg(neg),
        .busy(busy1), .done(done1), .an(an1), .code(code1)
    );

    always @(negedge clk) if (done0) n_done <= n_done + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // expected code of a slot for a displayed value v with effective sign s
    function automatic int exp_code(int v, bit s, int sl, bit lz);
        int h, t, u;
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        case (sl)
            0:       return u;
            1:       return s ? 10 : 11;
            2:       return (lz && h == 0) ? 11 : h;
            default: return (lz && v < 10) ? 11 : t;
        endcase
    endfunction

    function automatic int an_slot(logic [3:0] a);
        for (int i = 0; i < 4; i++)
            if (a == ~(4'b0001 << i)) return i;
        return -1;
    endfunction

    task automatic chk_disp(input int v, input bit s);
        bit         se;
        int         sl;
        logic [3:0] seen0, seen1;
        se    = s && (v != 0);
        seen0 = '0;
        seen1 = '0;
        repeat (5 * SD) @(negedge clk);
        repeat (4) begin
            repeat (SD) @(negedge clk);
            sl = an_slot(an0);
            chk("an0_onehot", sl >= 0, 1);
            if (sl >= 0) begin
                chk($sformatf("code0_v%0d_s%0d", v, sl), code0,
                    exp_code(v, se, sl, 1'b1));
                seen0[sl] = 1'b1;
            end
            sl = an_slot(an1);
            chk("an1_onehot", sl >= 0, 1);
            if (sl >= 0) begin
                chk($sformatf("code1_v%0d_s%0d", v, sl), code1,
                    exp_code(v, se, sl, 1'b0));
                seen1[sl] = 1'b1;
            end
        end
        chk("slots0", seen0, 4'hF);
        chk("slots1", seen1, 4'hF);
    endtask

    task automatic do_load(input logic [W-1:0] m, input bit n);
        @(negedge clk);
        load = 1'b1;
        mag  = m;
        neg  = n;
        @(negedge clk);
        load = 1'b0;
    endtask

    // single load from idle: check busy, done latency and display
    task automatic single(input int m, input bit n);
        int lat;
        do_load(W'(m), n);
        chk("busy_set", busy0, 1);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done0) begin
                lat = c;
                break;
            end
        end
        chk("latency", lat, W + 1);
        chk("busy_clr", busy0, 0);
        chk_disp(m, n);
    endtask

    // load a, then optional loads during the first conversion
    task automatic pend(input int a, input bit na, input bit [2:0] use_x,
                        input int x0, input int x1, input int x2);
        int fv, tend, base;
        bit fs;
        int xv[3];
        bit xs[3];
        xv[0] = x0; xv[1] = x1; xv[2] = x2;
        for (int j = 0; j < 3; j++) xs[j] = 1'($urandom_range(0, 1));
        fv = a;
        fs = na;
        for (int j = 0; j < 3; j++)
            if (use_x[j]) begin
                fv = xv[j];
                fs = xs[j];
            end
        #1 base = n_done;
        @(negedge clk);
        load = 1'b1;
        mag  = W'(a);
        neg  = na;
        tend = -1;
        for (int t = 0; t <= 60; t++) begin
            @(negedge clk);
            load = 1'b0;
            if (t >= 1 && !busy0) begin
                tend = t;
                break;
            end
            if (t == 1 || t == 3 || t == 5) begin
                if (use_x[t / 2]) begin
                    load = 1'b1;
                    mag  = W'(xv[t / 2]);
                    neg  = xs[t / 2];
                end
            end
        end
        load = 1'b0;
        #1;
        chk("busy_span", tend, (use_x != 0) ? 2 * W + 2 : W + 1);
        chk("done_count", n_done - base, (use_x != 0) ? 2 : 1);
        chk_disp(fv, fs);
    endtask

    task automatic chk_reset_and_tick();
        #1;
        chk("rst_an", an0, 4'b1111);
        chk("rst_code", code0, 11);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_an1", an1, 4'b1111);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (SD - 1) @(negedge clk);
        chk("pre_tick_an", an0, 4'b1111);
        @(negedge clk);
        chk("tick1_an", an0, 4'b1101);
        chk("tick1_code", code0, 11);
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        chk_reset_and_tick();

        single(165, 1'b1);
        single(7, 1'b0);
        single(0, 1'b1);
        single(255, 1'b0);
        pend(200, 1'b0, 3'b101, 42, 17, 99);

        for (int i = 0; i < 12; i++)
            single(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

        for (int i = 0; i < 8; i++)
            pend(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)));

        single(123, 1'b1);
        do_load(8'd88, 1'b1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        chk_reset_and_tick();
        #1 base = n_done;
        repeat (30) @(negedge clk);
        #1;
        chk("no_done_after_rst", n_done - base, 0);
        chk_disp(0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
